// File: rtl/dtc_pkg.sv
// Shared constants and types for the SRU-side DTC link master.
package dtc_pkg;
    localparam logic [7:0] CMD_SLOW = 8'hE1;
    localparam logic [7:0] CMD_E2   = 8'hE2;
    localparam logic [7:0] CMD_E4   = 8'hE4;
    localparam logic [7:0] CMD_E8   = 8'hE8;
    localparam logic [7:0] CMD_E9   = 8'hE9;
    localparam logic [7:0] CMD_EA   = 8'hEA;
    localparam logic [7:0] CMD_EF   = 8'hEF;

    localparam logic [15:0] HDR_RPL  = 16'hF7F7;
    localparam logic [15:0] HDR_STS  = 16'hDCDC;
    localparam logic [15:0] HDR_EVT  = 16'h5C5C;
    localparam logic [15:0] HDR_SYNC = 16'hBC50;

    typedef logic [3:0]  nib_t;
    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        DS_IDLE   = 3'd0,
        DS_EVT    = 3'd1,
        DS_RPL_HI = 3'd2,
        DS_RPL_LO = 3'd3,
        DS_STS    = 3'd4
    } dec_state_e;

    // Serial length in bits; unknown codes are sent as plain 8-bit fast codes.
    function automatic logic [6:0] cmd_len(logic [7:0] code);
        case (code)
            CMD_SLOW: return 7'd72;
            CMD_E2, CMD_E4, CMD_E8, CMD_E9, CMD_EA, CMD_EF: return 7'd8;
            default: return 7'd8;
        endcase
    endfunction

    function automatic logic is_known(word_t w);
        return (w == HDR_SYNC) || (w == HDR_EVT) || (w == HDR_RPL) || (w == HDR_STS);
    endfunction
endpackage

// File: rtl/dtc_sru_master_if.sv
// Link and user-side signal bundle of dtc_sru_master.
interface dtc_sru_master_if;
    import dtc_pkg::*;
    logic        trig_q1, trig_q2;
    logic        data_q1, data_q2, ret_q1, ret_q2;
    logic        l0_req, l1_req, trig_busy;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_code;
    logic [63:0] cmd_payload;
    logic        evt_valid, evt_sof, evt_eof;
    logic [11:0] evt_data;
    logic        rpl_valid;
    logic [31:0] rpl_data;
    logic        sts_valid;
    word_t       sts_data;
    logic        rx_locked, evt_err;

    modport master (
        output trig_q1, trig_q2, trig_busy, cmd_ready,
               evt_valid, evt_sof, evt_eof, evt_data,
               rpl_valid, rpl_data, sts_valid, sts_data, rx_locked, evt_err,
        input  data_q1, data_q2, ret_q1, ret_q2, l0_req, l1_req,
               cmd_valid, cmd_code, cmd_payload
    );
    modport slave (
        input  trig_q1, trig_q2, trig_busy, cmd_ready,
               evt_valid, evt_sof, evt_eof, evt_data,
               rpl_valid, rpl_data, sts_valid, sts_data, rx_locked, evt_err,
        output data_q1, data_q2, ret_q1, ret_q2, l0_req, l1_req,
               cmd_valid, cmd_code, cmd_payload
    );
endinterface

// File: rtl/dtc_word_aligner.sv
// Nibble shifter and 4-phase BC50 search; word_valid/word every 4 cycles once locked.
module dtc_word_aligner
    import dtc_pkg::*;
#(
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  nib_t  nib,
    input  logic  word_bad,
    output logic  word_valid,
    output word_t word,
    output logic  locked,
    output logic  unlock
);
    localparam int HW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);

    word_t                sr_q, sr_d;
    logic [1:0]           ph_cnt_q, ph_cnt_d, phase_q, phase_d;
    logic                 locked_q, locked_d;
    logic [3:0][HW-1:0]   hit_q, hit_d;
    logic [BW-1:0]        bad_q, bad_d;

    always_comb begin
        // Newest nibble enters at the top so the first nibble ends up least significant.
        sr_d       = {nib, sr_q[15:4]};
        ph_cnt_d   = ph_cnt_q + 2'd1;
        phase_d    = phase_q;
        locked_d   = locked_q;
        hit_d      = hit_q;
        bad_d      = bad_q;
        unlock     = 1'b0;
        word_valid = locked_q && (ph_cnt_q == phase_q);
        if (!locked_q) begin
            if (sr_q == HDR_SYNC) begin
                if (hit_q[ph_cnt_q] == HW'(LOCK_COUNT - 1)) begin
                    locked_d = 1'b1;
                    phase_d  = ph_cnt_q;
                    bad_d    = '0;
                end else begin
                    hit_d[ph_cnt_q] = hit_q[ph_cnt_q] + 1'b1;
                end
            end else begin
                hit_d[ph_cnt_q] = '0;
            end
        end else if (word_valid) begin
            if (word_bad) begin
                if (bad_q == BW'(UNLOCK_COUNT - 1)) begin
                    unlock   = 1'b1;
                    locked_d = 1'b0;
                    hit_d    = '0;
                    bad_d    = '0;
                end else begin
                    bad_d = bad_q + 1'b1;
                end
            end else begin
                bad_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q     <= '0;
            ph_cnt_q <= '0;
            phase_q  <= '0;
            locked_q <= 1'b0;
            hit_q    <= '0;
            bad_q    <= '0;
        end else begin
            sr_q     <= sr_d;
            ph_cnt_q <= ph_cnt_d;
            phase_q  <= phase_d;
            locked_q <= locked_d;
            hit_q    <= hit_d;
            bad_q    <= bad_d;
        end
    end

    assign word   = sr_q;
    assign locked = locked_q;
endmodule

// File: rtl/dtc_sru_master.sv
// SRU master end of one DTC link: trigger slots, command shifter, RX word decoder.
// DTC_SRU_ERRCNT_EN adds saturating error counters err_evt_cnt/err_unlock_cnt/err_trig_drop_cnt.
module dtc_sru_master
    import dtc_pkg::*;
#(
    parameter int LOCK_COUNT    = 8,
    parameter int UNLOCK_COUNT  = 4,
    parameter int MAX_EVT_WORDS = 4096
) (
    input  logic dtc_clk,
    input  logic rst,
    dtc_sru_master_if.master bus
`ifdef DTC_SRU_ERRCNT_EN
    ,
    output logic [15:0] err_evt_cnt,
    output logic [15:0] err_unlock_cnt,
    output logic [15:0] err_trig_drop_cnt
`endif
);
    localparam int CW = $clog2(MAX_EVT_WORDS + 1);
    localparam logic [1:0] TS_IDLE = 2'd0, TS_S0 = 2'd1, TS_S1 = 2'd2, TS_S2 = 2'd3;

    logic [1:0]  ts_q, ts_d;
    logic        ts_l1_q, ts_l1_d, trig_drop;
    logic [71:0] sh_q, sh_d;
    logic [6:0]  bits_q, bits_d;

    always_comb begin
        ts_d    = ts_q;
        ts_l1_d = ts_l1_q;
        case (ts_q)
            TS_IDLE: if (bus.l0_req || bus.l1_req) begin
                ts_d    = TS_S0;
                ts_l1_d = bus.l1_req;
            end
            TS_S0:   ts_d = TS_S1;
            TS_S1:   ts_d = TS_S2;
            default: ts_d = TS_IDLE;
        endcase
        trig_drop = (ts_q != TS_IDLE) && (bus.l0_req || bus.l1_req);

        sh_d   = sh_q;
        bits_d = bits_q;
        if (bits_q != 7'd0) begin
            sh_d   = {sh_q[70:0], 1'b0};
            bits_d = bits_q - 7'd1;
        end else if (bus.cmd_valid) begin
            sh_d   = {bus.cmd_code, (bus.cmd_code == CMD_SLOW) ? bus.cmd_payload : 64'd0};
            bits_d = cmd_len(bus.cmd_code);
        end
    end

    assign bus.trig_busy = (ts_q != TS_IDLE);
    assign bus.trig_q1   = (ts_q == TS_S0) || ((ts_q == TS_S1) && ts_l1_q);
    assign bus.cmd_ready = (bits_q == 7'd0);
    assign bus.trig_q2   = sh_q[71];

    logic  word_valid, word_bad, locked, unlock;
    word_t word;

    dtc_word_aligner #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_COUNT(UNLOCK_COUNT)) u_align (
        .clk(dtc_clk), .rst(rst),
        .nib({bus.ret_q2, bus.data_q2, bus.ret_q1, bus.data_q1}),
        .word_bad(word_bad), .word_valid(word_valid), .word(word),
        .locked(locked), .unlock(unlock)
    );

    dec_state_e   st_q, st_d;
    logic         hold_vld_q, hold_vld_d, hold_sof_q, hold_sof_d, first_q, first_d, ovf_q, ovf_d;
    logic [11:0]  hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         evt_valid_q, evt_valid_d, evt_sof_q, evt_sof_d, evt_eof_q, evt_eof_d;
    logic [11:0]  evt_data_q, evt_data_d;
    logic         rpl_valid_q, rpl_valid_d, sts_valid_q, sts_valid_d, evt_err_q, evt_err_d;
    logic [31:0]  rpl_data_q, rpl_data_d;
    word_t        sts_data_q, sts_data_d;
    logic         is_sample;

    always_comb begin
        st_d = st_q; hold_vld_d = hold_vld_q; hold_sof_d = hold_sof_q; first_d = first_q;
        ovf_d = ovf_q; hold_d = hold_q; cnt_d = cnt_q;
        evt_valid_d = 1'b0; evt_sof_d = 1'b0; evt_eof_d = 1'b0; evt_data_d = evt_data_q;
        rpl_valid_d = 1'b0; rpl_data_d = rpl_data_q;
        sts_valid_d = 1'b0; sts_data_d = sts_data_q; evt_err_d = 1'b0;
        is_sample = (word[15:12] == 4'h0);
        word_bad  = word_valid && !is_known(word) &&
                    ((st_q == DS_IDLE) || ((st_q == DS_EVT) && !is_sample));
        if (unlock) begin
            evt_err_d  = (st_q == DS_EVT);
            st_d       = DS_IDLE;
            hold_vld_d = 1'b0;
        end else if (word_valid) begin
            case (st_q)
                DS_IDLE: begin
                    case (word)
                        HDR_EVT: begin
                            st_d = DS_EVT; first_d = 1'b1; hold_vld_d = 1'b0;
                            ovf_d = 1'b0; cnt_d = '0;
                        end
                        HDR_RPL: st_d = DS_RPL_HI;
                        HDR_STS: st_d = DS_STS;
                        default: ;
                    endcase
                end
                DS_RPL_HI: begin rpl_data_d[31:16] = word; st_d = DS_RPL_LO; end
                DS_RPL_LO: begin rpl_data_d[15:0] = word; rpl_valid_d = 1'b1; st_d = DS_IDLE; end
                DS_STS:    begin sts_data_d = word; sts_valid_d = 1'b1; st_d = DS_IDLE; end
                DS_EVT: begin
                    // Samples are held one word so the trailing BC50 can mark eof on the last one.
                    if (word == HDR_SYNC) begin
                        if (hold_vld_q) begin
                            evt_valid_d = 1'b1; evt_sof_d = hold_sof_q; evt_eof_d = 1'b1;
                            evt_data_d  = hold_q;
                        end
                        hold_vld_d = 1'b0;
                        st_d       = DS_IDLE;
                    end else if (ovf_q) begin
                        st_d = DS_EVT;
                    end else if (is_sample) begin
                        if (hold_vld_q) begin
                            evt_valid_d = 1'b1; evt_sof_d = hold_sof_q; evt_data_d = hold_q;
                        end
                        if (cnt_q == CW'(MAX_EVT_WORDS)) begin
                            evt_err_d = 1'b1; ovf_d = 1'b1; hold_vld_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 1'b1; hold_vld_d = 1'b1; hold_d = word[11:0];
                            hold_sof_d = first_q; first_d = 1'b0;
                        end
                    end else begin
                        evt_err_d = 1'b1; hold_vld_d = 1'b0; st_d = DS_IDLE;
                    end
                end
                default: st_d = DS_IDLE;
            endcase
        end
    end

    always_ff @(posedge dtc_clk or posedge rst) begin
        if (rst) begin
            ts_q <= TS_IDLE; ts_l1_q <= 1'b0; sh_q <= '0; bits_q <= '0;
            st_q <= DS_IDLE; hold_vld_q <= 1'b0; hold_sof_q <= 1'b0; first_q <= 1'b0;
            ovf_q <= 1'b0; hold_q <= '0; cnt_q <= '0;
            evt_valid_q <= 1'b0; evt_sof_q <= 1'b0; evt_eof_q <= 1'b0; evt_data_q <= '0;
            rpl_valid_q <= 1'b0; rpl_data_q <= '0; sts_valid_q <= 1'b0; sts_data_q <= '0;
            evt_err_q <= 1'b0;
        end else begin
            ts_q <= ts_d; ts_l1_q <= ts_l1_d; sh_q <= sh_d; bits_q <= bits_d;
            st_q <= st_d; hold_vld_q <= hold_vld_d; hold_sof_q <= hold_sof_d; first_q <= first_d;
            ovf_q <= ovf_d; hold_q <= hold_d; cnt_q <= cnt_d;
            evt_valid_q <= evt_valid_d; evt_sof_q <= evt_sof_d; evt_eof_q <= evt_eof_d;
            evt_data_q <= evt_data_d; rpl_valid_q <= rpl_valid_d; rpl_data_q <= rpl_data_d;
            sts_valid_q <= sts_valid_d; sts_data_q <= sts_data_d; evt_err_q <= evt_err_d;
        end
    end

    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_sof   = evt_sof_q;
    assign bus.evt_eof   = evt_eof_q;
    assign bus.evt_data  = evt_data_q;
    assign bus.rpl_valid = rpl_valid_q;
    assign bus.rpl_data  = rpl_data_q;
    assign bus.sts_valid = sts_valid_q;
    assign bus.sts_data  = sts_data_q;
    assign bus.evt_err   = evt_err_q;
    assign bus.rx_locked = locked;

`ifdef DTC_SRU_ERRCNT_EN
    logic [15:0] ce_q, ce_d, cu_q, cu_d, ct_q, ct_d;
    always_comb begin
        ce_d = ce_q + 16'((evt_err_d && (ce_q != 16'hFFFF)) ? 1 : 0);
        cu_d = cu_q + 16'((unlock    && (cu_q != 16'hFFFF)) ? 1 : 0);
        ct_d = ct_q + 16'((trig_drop && (ct_q != 16'hFFFF)) ? 1 : 0);
    end
    always_ff @(posedge dtc_clk or posedge rst) begin
        if (rst) begin
            ce_q <= '0; cu_q <= '0; ct_q <= '0;
        end else begin
            ce_q <= ce_d; cu_q <= cu_d; ct_q <= ct_d;
        end
    end
    assign err_evt_cnt       = ce_q;
    assign err_unlock_cnt    = cu_q;
    assign err_trig_drop_cnt = ct_q;
`else
    logic unused_drop;
    assign unused_drop = trig_drop;
`endif
endmodule

// File: tb/tb_dtc_sru_master.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_dtc_sru_master;
    import dtc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dtc_sru_master_if bus();
`ifdef DTC_SRU_ERRCNT_EN
    logic [15:0] c_evt, c_unl, c_drop;
`endif

    dtc_sru_master dut (
        .dtc_clk(clk), .rst(rst), .bus(bus)
`ifdef DTC_SRU_ERRCNT_EN
        , .err_evt_cnt(c_evt), .err_unlock_cnt(c_unl), .err_trig_drop_cnt(c_drop)
`endif
    );

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    bit          q_trig[$];
    bit          q_cmd[$];
    logic [13:0] q_evt[$];
    logic [31:0] q_rpl[$];
    logic [15:0] q_sts[$];
    bit          q_err[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.trig_busy) begin
                if (q_trig.size() == 0) chk("trig_extra_slot", bus.trig_busy, 0);
                else begin bit e; e = q_trig.pop_front(); chk("trig_q1", bus.trig_q1, e); end
            end
            if (!bus.cmd_ready) begin
                if (q_cmd.size() == 0) chk("cmd_extra_bit", bus.cmd_ready, 1);
                else begin bit e; e = q_cmd.pop_front(); chk("trig_q2", bus.trig_q2, e); end
            end
            if (bus.evt_valid) begin
                if (q_evt.size() == 0) chk("evt_extra", bus.evt_valid, 0);
                else begin
                    logic [13:0] e; e = q_evt.pop_front();
                    chk("evt_beat", {bus.evt_sof, bus.evt_eof, bus.evt_data}, e);
                end
            end
            if (bus.rpl_valid) begin
                if (q_rpl.size() == 0) chk("rpl_extra", bus.rpl_valid, 0);
                else begin logic [31:0] e; e = q_rpl.pop_front(); chk("rpl_data", bus.rpl_data, e); end
            end
            if (bus.sts_valid) begin
                if (q_sts.size() == 0) chk("sts_extra", bus.sts_valid, 0);
                else begin logic [15:0] e; e = q_sts.pop_front(); chk("sts_data", bus.sts_data, e); end
            end
            if (bus.evt_err) begin
                if (q_err.size() == 0) chk("evt_err_extra", bus.evt_err, 0);
                else begin bit e; e = q_err.pop_front(); chk("evt_err", bus.evt_err, e); end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_nib(nib_t n);
        {bus.ret_q2, bus.data_q2, bus.ret_q1, bus.data_q1} = n;
        cyc(1);
    endtask

    task automatic send_word(word_t w);
        for (int i = 0; i < 4; i++) put_nib(w[4*i +: 4]);
    endtask

    task automatic check_idle_outputs(string tag);
        chk({tag, "_trig_q1"}, bus.trig_q1, 0);
        chk({tag, "_trig_q2"}, bus.trig_q2, 0);
        chk({tag, "_trig_busy"}, bus.trig_busy, 0);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_evt_valid"}, bus.evt_valid, 0);
        chk({tag, "_evt_eof"}, bus.evt_eof, 0);
        chk({tag, "_evt_data"}, bus.evt_data, 0);
        chk({tag, "_rpl_data"}, bus.rpl_data, 0);
        chk({tag, "_sts_data"}, bus.sts_data, 0);
        chk({tag, "_evt_err"}, bus.evt_err, 0);
        chk({tag, "_rx_locked"}, bus.rx_locked, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [71:0] v;
        logic [7:0]  f;
        {bus.l0_req, bus.l1_req, bus.cmd_valid} = '0;
        bus.cmd_code = '0; bus.cmd_payload = '0;
        {bus.ret_q2, bus.data_q2, bus.ret_q1, bus.data_q1} = '0;
        #23;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        cyc(2);

        // L1 slot, L0 dropped while busy, back-to-back L0, then simultaneous L0+L1
        q_trig.push_back(1); q_trig.push_back(1); q_trig.push_back(0);
        bus.l1_req = 1; cyc(1);
        bus.l1_req = 0; bus.l0_req = 1; cyc(1);
        bus.l0_req = 0; cyc(2);
        chk("trig_busy_fell", bus.trig_busy, 0);
        q_trig.push_back(1); q_trig.push_back(0); q_trig.push_back(0);
        bus.l0_req = 1; cyc(1);
        bus.l0_req = 0; cyc(4);
        q_trig.push_back(1); q_trig.push_back(1); q_trig.push_back(0);
        bus.l0_req = 1; bus.l1_req = 1; cyc(1);
        bus.l0_req = 0; bus.l1_req = 0; cyc(4);
        chk("trig_queue_drained", q_trig.size(), 0);

        // Slow command, 72 bits MSB first
        v = {8'hE1, 64'h8000_1234_0000_0000};
        for (int i = 71; i >= 0; i--) q_cmd.push_back(v[i]);
        bus.cmd_code = 8'hE1; bus.cmd_payload = 64'h8000_1234_0000_0000; bus.cmd_valid = 1;
        cyc(1);
        bus.cmd_valid = 0;
        cyc(75);
        chk("cmd_slow_drained", q_cmd.size(), 0);
        // Fast command, payload must be ignored
        f = 8'hE4;
        for (int i = 7; i >= 0; i--) q_cmd.push_back(f[i]);
        bus.cmd_code = 8'hE4; bus.cmd_payload = 64'hFFFF_FFFF_FFFF_FFFF; bus.cmd_valid = 1;
        cyc(1);
        bus.cmd_valid = 0;
        cyc(12);
        chk("cmd_fast_drained", q_cmd.size(), 0);

        // Lock at nibble phase 2, then unlock by bad words
        put_nib(4'h0); put_nib(4'h0);
        repeat (9) send_word(HDR_SYNC);
        chk("locked_after_sync", bus.rx_locked, 1);
        repeat (3) send_word(16'h1234);
        chk("locked_after_3_bad", bus.rx_locked, 1);
        send_word(16'h1234);
        send_word(HDR_SYNC);
        chk("unlocked_after_4_bad", bus.rx_locked, 0);
        repeat (9) send_word(HDR_SYNC);
        chk("relocked", bus.rx_locked, 1);

        // Three-sample event
        q_evt.push_back({2'b10, 12'h003});
        q_evt.push_back({2'b00, 12'h0A5});
        q_evt.push_back({2'b01, 12'hFFF});
        send_word(HDR_EVT); send_word(16'h0003); send_word(16'h00A5); send_word(16'h0FFF);
        send_word(HDR_SYNC); send_word(HDR_SYNC); send_word(HDR_SYNC);
        chk("evt_drained", q_evt.size(), 0);

        // Single-sample and empty events
        q_evt.push_back({2'b11, 12'h123});
        send_word(HDR_EVT); send_word(16'h0123); send_word(HDR_SYNC); send_word(HDR_SYNC);
        send_word(HDR_EVT); send_word(HDR_SYNC); send_word(HDR_SYNC);

        // Slow-read reply and status word
        q_rpl.push_back(32'hDEADBEEF);
        send_word(HDR_RPL); send_word(16'hDEAD); send_word(16'hBEEF); send_word(HDR_SYNC);
        q_sts.push_back(16'h0042);
        send_word(HDR_STS); send_word(16'h0042); send_word(HDR_SYNC); send_word(HDR_SYNC);

        // Malformed event: header inside event
        q_err.push_back(1);
        send_word(HDR_EVT); send_word(16'h0001); send_word(HDR_STS);
        send_word(HDR_SYNC); send_word(HDR_SYNC);
        chk("locked_before_rst", bus.rx_locked, 1);

        // Reset mid-event
        send_word(HDR_EVT); send_word(16'h0002);
        put_nib(4'h3);
        rst = 1'b1;
        #2;
        check_idle_outputs("midrst");
        cyc(2);
        rst = 1'b0;
        {bus.ret_q2, bus.data_q2, bus.ret_q1, bus.data_q1} = '0;
        cyc(10);
        chk("post_rst_locked", bus.rx_locked, 0);

        chk("q_trig_empty", q_trig.size(), 0);
        chk("q_cmd_empty", q_cmd.size(), 0);
        chk("q_evt_empty", q_evt.size(), 0);
        chk("q_rpl_empty", q_rpl.size(), 0);
        chk("q_sts_empty", q_sts.size(), 0);
        chk("q_err_empty", q_err.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
